// File: rtl/ahb_arbiter_m2s.sv
// Master-to-slave half of a 4-master AHB interconnect: fixed-priority arbiter
// with registered grants, address/control mux on HMASTER and write-data mux on DMASTER.
module ahb_arbiter_m2s (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HBUSREQ_M0,
  input  logic        HBUSREQ_M1,
  input  logic        HBUSREQ_M2,
  input  logic        HBUSREQ_M3,
  input  logic        HLOCK_M0,
  input  logic        HLOCK_M1,
  input  logic        HLOCK_M2,
  input  logic        HLOCK_M3,
  input  logic [1:0]  HTRANS_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic [1:0]  HTRANS_M2,
  input  logic [1:0]  HTRANS_M3,
  input  logic [31:0] HADDR_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [31:0] HADDR_M2,
  input  logic [31:0] HADDR_M3,
  input  logic        HWRITE_M0,
  input  logic        HWRITE_M1,
  input  logic        HWRITE_M2,
  input  logic        HWRITE_M3,
  input  logic [2:0]  HSIZE_M0,
  input  logic [2:0]  HSIZE_M1,
  input  logic [2:0]  HSIZE_M2,
  input  logic [2:0]  HSIZE_M3,
  input  logic [2:0]  HBURST_M0,
  input  logic [2:0]  HBURST_M1,
  input  logic [2:0]  HBURST_M2,
  input  logic [2:0]  HBURST_M3,
  input  logic [31:0] HWDATA_M0,
  input  logic [31:0] HWDATA_M1,
  input  logic [31:0] HWDATA_M2,
  input  logic [31:0] HWDATA_M3,
  input  logic        HREADY,
  output logic        HGRANT_M0,
  output logic        HGRANT_M1,
  output logic        HGRANT_M2,
  output logic        HGRANT_M3,
  output logic [1:0]  HMASTER,
  output logic        HMASTLOCK,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA
);

  localparam int NUM_M = 4;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  logic [NUM_M-1:0] busreq;
  logic [NUM_M-1:0] hlock;
  logic [1:0]       trans_m [NUM_M];
  logic [31:0]      addr_m  [NUM_M];
  logic             write_m [NUM_M];
  logic [2:0]       size_m  [NUM_M];
  logic [2:0]       burst_m [NUM_M];
  logic [31:0]      wdata_m [NUM_M];

  assign busreq = {HBUSREQ_M3, HBUSREQ_M2, HBUSREQ_M1, HBUSREQ_M0};
  assign hlock  = {HLOCK_M3, HLOCK_M2, HLOCK_M1, HLOCK_M0};

  assign trans_m[0] = HTRANS_M0;
  assign trans_m[1] = HTRANS_M1;
  assign trans_m[2] = HTRANS_M2;
  assign trans_m[3] = HTRANS_M3;
  assign addr_m[0]  = HADDR_M0;
  assign addr_m[1]  = HADDR_M1;
  assign addr_m[2]  = HADDR_M2;
  assign addr_m[3]  = HADDR_M3;
  assign write_m[0] = HWRITE_M0;
  assign write_m[1] = HWRITE_M1;
  assign write_m[2] = HWRITE_M2;
  assign write_m[3] = HWRITE_M3;
  assign size_m[0]  = HSIZE_M0;
  assign size_m[1]  = HSIZE_M1;
  assign size_m[2]  = HSIZE_M2;
  assign size_m[3]  = HSIZE_M3;
  assign burst_m[0] = HBURST_M0;
  assign burst_m[1] = HBURST_M1;
  assign burst_m[2] = HBURST_M2;
  assign burst_m[3] = HBURST_M3;
  assign wdata_m[0] = HWDATA_M0;
  assign wdata_m[1] = HWDATA_M1;
  assign wdata_m[2] = HWDATA_M2;
  assign wdata_m[3] = HWDATA_M3;

  logic [NUM_M-1:0] hgrant_reg;
  logic [NUM_M-1:0] hgrant_next;
  logic [NUM_M-1:0] pri_onehot;
  logic [1:0]       hmaster_reg;
  logic [1:0]       dmaster_reg;
  logic [1:0]       grant_idx;
  logic [3:0]       bcnt_reg;
  logic [3:0]       bcnt_next;
  logic             locked_reg;
  logic             arb;

  // Fixed priority: a requester wins only if no lower-indexed master requests.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_pri
      if (gi == 0) begin : g_top
        assign pri_onehot[gi] = busreq[gi];
      end else begin : g_rest
        assign pri_onehot[gi] = busreq[gi] & ~(|busreq[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    grant_idx = 2'd0;
    for (int i = 0; i < NUM_M; i++) begin
      if (hgrant_reg[i]) grant_idx = 2'(i);
    end
  end

  assign arb = HREADY & (bcnt_reg == 4'd0) & ~locked_reg;

  always_comb begin
    hgrant_next = hgrant_reg;
    if (arb) hgrant_next = (|busreq) ? pri_onehot : 4'b0001;
  end

  // Remaining beats of the owner's fixed-length burst; undefined INCR keeps it at 0.
  always_comb begin
    bcnt_next = bcnt_reg;
    case (HTRANS)
      TRANS_IDLE: bcnt_next = 4'd0;
      TRANS_BUSY: bcnt_next = bcnt_reg;
      TRANS_NONSEQ: begin
        case (HBURST)
          3'b010, 3'b011: bcnt_next = 4'd3;
          3'b100, 3'b101: bcnt_next = 4'd7;
          3'b110, 3'b111: bcnt_next = 4'd15;
          default:        bcnt_next = 4'd0;
        endcase
      end
      TRANS_SEQ: begin
        if (bcnt_reg != 4'd0) bcnt_next = bcnt_reg - 4'd1;
      end
      default: bcnt_next = bcnt_reg;
    endcase
  end

  // The lock flag and HMASTLOCK are both sampled from the granted master as it takes the bus.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hgrant_reg  <= 4'b0001;
      hmaster_reg <= 2'd0;
      dmaster_reg <= 2'd0;
      bcnt_reg    <= 4'd0;
      locked_reg  <= 1'b0;
    end else begin
      hgrant_reg <= hgrant_next;
      if (HREADY) begin
        hmaster_reg <= grant_idx;
        dmaster_reg <= hmaster_reg;
        bcnt_reg    <= bcnt_next;
        locked_reg  <= hlock[grant_idx];
      end
    end
  end

  assign HGRANT_M0 = hgrant_reg[0];
  assign HGRANT_M1 = hgrant_reg[1];
  assign HGRANT_M2 = hgrant_reg[2];
  assign HGRANT_M3 = hgrant_reg[3];
  assign HMASTER   = hmaster_reg;
  assign HMASTLOCK = locked_reg;

  assign HTRANS = trans_m[hmaster_reg];
  assign HADDR  = addr_m[hmaster_reg];
  assign HWRITE = write_m[hmaster_reg];
  assign HSIZE  = size_m[hmaster_reg];
  assign HBURST = burst_m[hmaster_reg];
  assign HWDATA = wdata_m[dmaster_reg];

endmodule

// File: tb/tb_ahb_arbiter_m2s.sv
// Bench for ahb_arbiter_m2s: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant, ownership, burst length and lock.
module tb_ahb_arbiter_m2s;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HREADY = 1'b1;
  logic [3:0]  busreq = 4'b0000;
  logic [3:0]  hlock = 4'b0000;
  logic [3:0]  hwrite = 4'b0000;
  logic [1:0]  htrans [4];
  logic [31:0] haddr  [4];
  logic [31:0] hwdata [4];
  logic [2:0]  hsize  [4];
  logic [2:0]  hburst [4];

  logic [3:0]  grant;
  logic [1:0]  o_hmaster;
  logic        o_hmastlock;
  logic [1:0]  o_htrans;
  logic [31:0] o_haddr;
  logic        o_hwrite;
  logic [2:0]  o_hsize;
  logic [2:0]  o_hburst;
  logic [31:0] o_hwdata;

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_m2s dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ_M0(busreq[0]), .HBUSREQ_M1(busreq[1]), .HBUSREQ_M2(busreq[2]), .HBUSREQ_M3(busreq[3]),
    .HLOCK_M0(hlock[0]), .HLOCK_M1(hlock[1]), .HLOCK_M2(hlock[2]), .HLOCK_M3(hlock[3]),
    .HTRANS_M0(htrans[0]), .HTRANS_M1(htrans[1]), .HTRANS_M2(htrans[2]), .HTRANS_M3(htrans[3]),
    .HADDR_M0(haddr[0]), .HADDR_M1(haddr[1]), .HADDR_M2(haddr[2]), .HADDR_M3(haddr[3]),
    .HWRITE_M0(hwrite[0]), .HWRITE_M1(hwrite[1]), .HWRITE_M2(hwrite[2]), .HWRITE_M3(hwrite[3]),
    .HSIZE_M0(hsize[0]), .HSIZE_M1(hsize[1]), .HSIZE_M2(hsize[2]), .HSIZE_M3(hsize[3]),
    .HBURST_M0(hburst[0]), .HBURST_M1(hburst[1]), .HBURST_M2(hburst[2]), .HBURST_M3(hburst[3]),
    .HWDATA_M0(hwdata[0]), .HWDATA_M1(hwdata[1]), .HWDATA_M2(hwdata[2]), .HWDATA_M3(hwdata[3]),
    .HREADY(HREADY),
    .HGRANT_M0(grant[0]), .HGRANT_M1(grant[1]), .HGRANT_M2(grant[2]), .HGRANT_M3(grant[3]),
    .HMASTER(o_hmaster), .HMASTLOCK(o_hmastlock),
    .HTRANS(o_htrans), .HADDR(o_haddr), .HWRITE(o_hwrite), .HSIZE(o_hsize), .HBURST(o_hburst),
    .HWDATA(o_hwdata)
  );

  // Reference model: who holds the grant, who owns address and data phases,
  // how many beats of a fixed-length burst are still to come, and whether the bus is locked.
  int burst_len [8] = '{1, 1, 4, 4, 8, 8, 16, 16};
  int m_grant = 0;
  int m_owner = 0;
  int m_downer = 0;
  int m_left = 0;
  bit m_lock = 1'b0;

  function automatic int first_req(logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return 0;
  endfunction

  always @(posedge HCLK) begin
    if (HRESET) begin
      m_grant <= 0; m_owner <= 0; m_downer <= 0; m_left <= 0; m_lock <= 1'b0;
    end else begin
      if (HREADY && m_left == 0 && !m_lock) m_grant <= first_req(busreq);
      if (HREADY) begin
        m_owner  <= m_grant;
        m_downer <= m_owner;
        m_lock   <= hlock[m_grant];
        if (htrans[m_owner] == 2'b00) m_left <= 0;
        else if (htrans[m_owner] == 2'b10) m_left <= burst_len[hburst[m_owner]] - 1;
        else if (htrans[m_owner] == 2'b11 && m_left > 0) m_left <= m_left - 1;
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    busreq = 4'b0000;
    hlock  = 4'b0000;
    HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      htrans[i] = 2'b00;
      hburst[i] = 3'b000;
      hsize[i]  = 3'b010;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (grant !== 4'b0001) begin failures++; $display("FAIL reset_grant cyc=%0d got=%b want=0001", c, grant); end
      checks++;
      if (o_hmaster !== 2'd0) begin failures++; $display("FAIL reset_hmaster cyc=%0d got=%0d want=0", c, o_hmaster); end
      checks++;
      if (o_haddr !== haddr[0]) begin failures++; $display("FAIL reset_haddr cyc=%0d got=%h want=%h", c, o_haddr, haddr[0]); end
      checks++;
      if (o_hmastlock !== 1'b0) begin failures++; $display("FAIL reset_hmastlock cyc=%0d got=%b want=0", c, o_hmastlock); end
      tick();
    end
    $display("test_reset: idle hold done, grant=%b hmaster=%0d", grant, o_hmaster);
  endtask

  task automatic test_grant_latency();
    do_reset();
    busreq[2] = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0100) begin failures++; $display("FAIL m2_grant got=%b want=0100", grant); end
    tick();
    checks++;
    if (o_hmaster !== 2'd2) begin failures++; $display("FAIL m2_hmaster got=%0d want=2", o_hmaster); end
    checks++;
    if (o_haddr !== haddr[2]) begin failures++; $display("FAIL m2_haddr got=%h want=%h", o_haddr, haddr[2]); end
    tick();
    checks++;
    if (o_hwdata !== hwdata[2]) begin failures++; $display("FAIL m2_hwdata got=%h want=%h", o_hwdata, hwdata[2]); end
    $display("test_grant_latency: M2 grant->addr->data sequence done");
  endtask

  task automatic test_burst_incr4();
    do_reset();
    busreq[1] = 1'b1;
    tick();
    tick();
    htrans[1] = 2'b10;
    hburst[1] = 3'b011;
    tick();
    htrans[1] = 2'b11;
    busreq[0] = 1'b1;
    for (int b = 2; b <= 4; b++) begin
      tick();
      checks++;
      if (grant !== 4'b0010) begin failures++; $display("FAIL incr4_hold beat=%0d got=%b want=0010", b, grant); end
    end
    htrans[1] = 2'b00;
    tick();
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL incr4_regrant got=%b want=0001", grant); end
    $display("test_burst_incr4: M1 burst done, grant now %b", grant);
  endtask

  task automatic test_wait_states();
    do_reset();
    busreq[1] = 1'b1;
    tick();
    tick();
    tick();
    busreq[1] = 1'b0;
    busreq[3] = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b1000) begin failures++; $display("FAIL wait_grant got=%b want=1000", grant); end
    HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++;
      if (o_hmaster !== 2'd1) begin failures++; $display("FAIL wait_hmaster w=%0d got=%0d want=1", w, o_hmaster); end
      checks++;
      if (o_hwdata !== hwdata[1]) begin failures++; $display("FAIL wait_hwdata w=%0d got=%h want=%h", w, o_hwdata, hwdata[1]); end
    end
    HREADY = 1'b1;
    tick();
    checks++;
    if (o_hmaster !== 2'd3) begin failures++; $display("FAIL wait_switch got=%0d want=3", o_hmaster); end
    checks++;
    if (o_hwdata !== hwdata[1]) begin failures++; $display("FAIL wait_data_lag got=%h want=%h", o_hwdata, hwdata[1]); end
    tick();
    checks++;
    if (o_hwdata !== hwdata[3]) begin failures++; $display("FAIL wait_data_switch got=%h want=%h", o_hwdata, hwdata[3]); end
    $display("test_wait_states: handover M1->M3 across 3 wait states done");
  endtask

  task automatic test_lock();
    do_reset();
    busreq[2] = 1'b1;
    hlock[2]  = 1'b1;
    htrans[2] = 2'b10;
    hburst[2] = 3'b000;
    tick();
    tick();
    checks++;
    if (o_hmastlock !== 1'b1) begin failures++; $display("FAIL lock_mastlock got=%b want=1", o_hmastlock); end
    busreq[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0100) begin failures++; $display("FAIL lock_hold c=%0d got=%b want=0100", c, grant); end
      checks++;
      if (o_hmastlock !== 1'b1) begin failures++; $display("FAIL lock_mastlock_hold c=%0d got=%b want=1", c, o_hmastlock); end
    end
    hlock[2] = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0100) begin failures++; $display("FAIL unlock_early got=%b want=0100", grant); end
    tick();
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL unlock_grant got=%b want=0001", grant); end
    $display("test_lock: M2 locked sequence released to M0");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    busreq[3] = 1'b1;
    hlock[3]  = 1'b1;
    tick();
    tick();
    htrans[3] = 2'b10;
    hburst[3] = 3'b101;
    tick();
    htrans[3] = 2'b11;
    tick();
    tick();
    HRESET = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL rstmid_grant got=%b want=0001", grant); end
    checks++;
    if (o_hmaster !== 2'd0) begin failures++; $display("FAIL rstmid_hmaster got=%0d want=0", o_hmaster); end
    checks++;
    if (o_hmastlock !== 1'b0) begin failures++; $display("FAIL rstmid_hmastlock got=%b want=0", o_hmastlock); end
    HRESET = 1'b0;
    idle_inputs();
    busreq[1] = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0010) begin failures++; $display("FAIL rstmid_bcnt_clear got=%b want=0010", grant); end
    $display("test_reset_mid_burst: INCR8 aborted by reset");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      busreq = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        hlock[i]  = ($urandom_range(0, 9) == 0);
        htrans[i] = 2'($urandom_range(0, 3));
        hburst[i] = 3'($urandom_range(0, 7));
        hsize[i]  = 3'($urandom_range(0, 2));
        hwrite[i] = 1'($urandom_range(0, 1));
        haddr[i]  = $urandom;
        hwdata[i] = $urandom;
      end
      HREADY = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (grant !== (4'b0001 << m_grant) || $countones(grant) != 1)
        begin failures++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, grant, 4'b0001 << m_grant); end
      checks++;
      if (o_hmaster !== 2'(m_owner)) begin failures++; $display("FAIL rnd_hmaster c=%0d got=%0d want=%0d", c, o_hmaster, m_owner); end
      checks++;
      if (o_hmastlock !== m_lock) begin failures++; $display("FAIL rnd_hmastlock c=%0d got=%b want=%b", c, o_hmastlock, m_lock); end
      checks++;
      if (o_haddr !== haddr[m_owner] || o_htrans !== htrans[m_owner] || o_hwrite !== hwrite[m_owner] ||
          o_hsize !== hsize[m_owner] || o_hburst !== hburst[m_owner])
        begin failures++; $display("FAIL rnd_addr_mux c=%0d got=%h/%b want=%h/%b", c, o_haddr, o_htrans, haddr[m_owner], htrans[m_owner]); end
      checks++;
      if (o_hwdata !== hwdata[m_downer]) begin failures++; $display("FAIL rnd_hwdata c=%0d got=%h want=%h", c, o_hwdata, hwdata[m_downer]); end
      $display("rnd c=%0d ready=%b req=%b grant=%b hmaster=%0d lock=%b left=%0d", c, HREADY, busreq, grant, o_hmaster, o_hmastlock, m_left);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      haddr[i]  = 32'h1000_0000 * (i + 1) + $urandom_range(0, 255);
      hwdata[i] = 32'hA000_0000 + 32'(i) * 32'h0111_1111;
      htrans[i] = 2'b00;
      hburst[i] = 3'b000;
      hsize[i]  = 3'b010;
    end
    test_reset();
    test_grant_latency();
    test_burst_incr4();
    test_wait_states();
    test_lock();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
